// File: rtl/byte_batcher_pkg.sv
// byte_batcher_pkg: shared widths for the byte-to-AES-block batcher
package byte_batcher_pkg;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_BATCH = 16;
  localparam int AES_BLOCK_W = BYTE_W * BYTES_PER_BATCH;
endpackage

// File: rtl/byte_batcher.sv
// byte_batcher: packs a strobed byte stream MSB-first into blocks on a valid/ready output
module byte_batcher #(
  parameter int BYTE_W = byte_batcher_pkg::BYTE_W,
  parameter int BYTES_PER_BATCH = byte_batcher_pkg::BYTES_PER_BATCH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BYTE_W-1:0]                  rx_data,
  input  logic                               rx_valid,
  output logic [BYTE_W*BYTES_PER_BATCH-1:0]  batch_data,
  output logic                               batch_valid,
  input  logic                               aes_ready,
  output logic                               overflow
);
  localparam int W = BYTE_W * BYTES_PER_BATCH;
  localparam int CW = $clog2(BYTES_PER_BATCH);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_BATCH - 1);
  logic [W-1:0] shift_q, shift_d, data_q, data_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, full_d, valid_q, valid_d, ovf_q, ovf_d, out_free, last;
  assign shifted = {shift_q[W-BYTE_W-1:0], rx_data};
  assign out_free = !valid_q || aes_ready;
  assign last = cnt_q == LAST;
  always_comb begin
    shift_d = shift_q;
    cnt_d = cnt_q;
    full_d = full_q;
    data_d = data_q;
    valid_d = valid_q && !aes_ready;
    ovf_d = 1'b0;
    if (full_q) begin
      // a held block drains first; a byte on the same edge starts the next block
      if (out_free) begin
        data_d = shift_q;
        valid_d = 1'b1;
        full_d = 1'b0;
        cnt_d = rx_valid ? CW'(1) : '0;
        shift_d = rx_valid ? W'(rx_data) : '0;
      end else ovf_d = rx_valid;
    end else if (rx_valid) begin
      shift_d = shifted;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        if (out_free) begin
          data_d = shifted;
          valid_d = 1'b1;
        end else full_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end
  assign batch_data = data_q;
  assign batch_valid = valid_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_byte_batcher.sv
// tb_byte_batcher: table vectors, corner sequences and random traffic against a queue model
module tb_byte_batcher;
  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, aes_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic [127:0] batch_data;
  logic batch_valid, overflow;
  int checks = 0, errors = 0;
  byte_batcher dut (.clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .batch_data(batch_data), .batch_valid(batch_valid), .aes_ready(aes_ready), .overflow(overflow));
  always #5 clk = ~clk;
  typedef struct {logic rv; logic [7:0] rd; logic rdy; logic ev; logic eo; logic [127:0] ed;} vec_t;
  vec_t tbl[$];
  logic [7:0] col[$];
  logic m_valid = 1'b0, m_ovf = 1'b0;
  logic [127:0] m_data = '0;
  function automatic logic [127:0] pack(input logic [7:0] q[$]);
    logic [127:0] d = '0;
    foreach (q[i]) d = {d[119:0], q[i]};
    return d;
  endfunction
  function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic rdy, input logic ev, input logic eo, input logic [127:0] ed);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rdy = rdy; v.ev = ev; v.eo = eo; v.ed = ed;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic model_reset();
    col.delete(); m_valid = 1'b0; m_ovf = 1'b0; m_data = '0;
  endtask
  task automatic step(input logic rv, input logic [7:0] rd, input logic rdy);
    logic free;
    rx_valid = rv; rx_data = rd; aes_ready = rdy;
    @(posedge clk);
    free = !m_valid || rdy;
    m_ovf = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (col.size() == 16) begin
      if (free) begin
        m_data = pack(col); m_valid = 1'b1; col.delete();
        if (rv) col.push_back(rd);
      end else if (rv) m_ovf = 1'b1;
    end else if (rv) begin
      col.push_back(rd);
      if (col.size() == 16 && free) begin
        m_data = pack(col); m_valid = 1'b1; col.delete();
      end
    end
    #1;
    chk("model_valid", batch_valid, m_valid);
    chk("model_ovf", overflow, m_ovf);
    if (m_valid) chk("model_data", batch_data, m_data);
  endtask
  initial begin
    logic [127:0] blk;
    for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 8'(i), 1, 0, 0, '0));
    tbl.push_back(mk(1, 8'h0F, 1, 1, 0, 128'h000102030405060708090A0B0C0D0E0F));
    tbl.push_back(mk(0, 0, 1, 0, 0, '0));
    for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 8'(8'h10 + i), 0, 0, 0, '0));
    blk = 128'h101112131415161718191A1B1C1D1E1F;
    tbl.push_back(mk(1, 8'h1F, 0, 1, 0, blk));
    for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 0, 0, 1, 0, blk));
    tbl.push_back(mk(0, 0, 1, 0, 0, blk));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", batch_valid, 0);
    chk("rst_data", batch_data, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    model_reset();
    step(0, 0, 1);
    chk("post_rst_valid", batch_valid, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      chk("tbl_valid", batch_valid, tbl[i].ev);
      chk("tbl_ovf", overflow, tbl[i].eo);
      if (tbl[i].ev) chk("tbl_data", batch_data, tbl[i].ed);
    end
    for (int i = 0; i < 32; i++) step(1, 8'(8'h20 + i), 0);
    chk("pipe_first_held", batch_data, 128'h202122232425262728292A2B2C2D2E2F);
    step(1, 8'hEE, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_hold", batch_data, 128'h202122232425262728292A2B2C2D2E2F);
    step(0, 0, 0);
    chk("drop_pulse_end", overflow, 0);
    step(1, 8'hAA, 1);
    chk("drain_ovf", overflow, 0);
    chk("drain_valid", batch_valid, 1);
    chk("drain_second", batch_data, 128'h303132333435363738393A3B3C3D3E3F);
    step(0, 0, 1);
    chk("drain_valid_drop", batch_valid, 0);
    for (int i = 1; i < 16; i++) step(1, 8'(i), 1);
    chk("aa_lead_valid", batch_valid, 1);
    chk("aa_lead_data", batch_data, 128'hAA0102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 7; i++) step(1, 8'(8'h50 + i), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", batch_valid, 0);
    chk("midrst_data", batch_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 1);
    chk("midrst_block", batch_data, 128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 3));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_batcher.md
Name: byte_batcher

Overview:
- Collects a serial stream of 8-bit bytes (e.g. from a UART receiver) into 128-bit blocks for the downstream AES engine.
- Presents each completed block on a valid/ready output interface.
- Sits between the byte receiver and the AES core in the modem datapath.
- The first byte received lands in the most-significant byte of the block.

Parameters:
- BYTE_W, 8, width of one input byte.
- BYTES_PER_BATCH, 16, bytes per output block; output width = BYTE_W*BYTES_PER_BATCH (128 at defaults).

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming byte, sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per byte; no backpressure is available upstream.
- batch_data  output  128  assembled block; byte 0 at [127:120], byte 15 at [7:0].
- batch_valid  output  1  block available on batch_data.
- aes_ready  input  1  downstream accepts the block on any edge where batch_valid=1.
- overflow  output  1  one-cycle pulse when an incoming byte is dropped.

Behaviour:
- Reset (asynchronous, active-high): collector shift register=0, byte count=0, collector-full flag=0, batch_data=0, batch_valid=0, overflow=0.
- Collector operation:
  - On each rising edge with rx_valid=1 and collector not full: shift_reg <= {shift_reg[119:0], rx_data}; count increments.
  - Result after bytes 0x00..0x0F: 128'h000102030405060708090A0B0C0D0E0F.
- Completion:
  - The 16th accepted byte completes the block (count wraps 15->0).
  - If the output register is free (batch_valid=0, or batch_valid=1 with aes_ready=1 on the same edge), the completed value {shift_reg[119:0], rx_data} loads directly into batch_data.
  - batch_valid goes 1 on that same edge, i.e. zero extra cycles after the edge that samples byte 16.
- Output busy at completion:
  - The block is held in the collector and the collector-full flag is set.
  - It moves to batch_data on the first edge where the output register frees. The collector then clears to empty (count=0, flag=0).
- Handshake:
  - The transfer occurs on an edge where batch_valid=1 and aes_ready=1. batch_valid drops on that edge unless a new block loads simultaneously, in which case it stays 1 with new data.
  - While batch_valid=1 and aes_ready=0, batch_data and batch_valid hold stable.
  - aes_ready has no effect while batch_valid=0.
  - batch_data retains the last value after transfer; it is don't-care when batch_valid=0.
- Drop rule: when rx_valid=1 arrives while the collector is full and the output cannot free on that edge, the byte is discarded and overflow pulses for one cycle. No state changes.
- Simultaneous full-collector drain and rx_valid on the same edge: the collector moves to the output and the incoming byte becomes byte 0 of the next block (count=1). No drop.
- Partial block: stays in the collector indefinitely. There is no timeout or flush.
- Reset asserted mid-block or mid-handshake discards all state immediately.

Decomposition:
- Shared package (e.g. zmodem_pkg): BYTE_W, AES_BLOCK_W=128, BYTES_PER_BATCH constants.
- A single module is sufficient; no sub-module required. The collector and output register are two always_ff processes in the same file.

Test Plan:
- Reset: hold reset=1, then release -> batch_valid=0, batch_data=0, overflow=0 throughout.
- Basic block: 16 single-cycle rx_valid pulses with data 0x00..0x0F, aes_ready=1 -> batch_valid rises on the edge sampling 0x0F; batch_data=128'h000102030405060708090A0B0C0D0E0F; batch_valid=0 one cycle later.
- Backpressure: aes_ready=0, send bytes 0x10..0x1F -> batch_valid=1 with data 0x101112...1F held stable for 20 cycles. Raise aes_ready -> valid clears after one edge.
- Pipelined blocks and drop: aes_ready=0, send 32 bytes, then one more -> first block held on output, second in collector, 33rd byte gives an overflow pulse. Raise aes_ready -> both blocks delivered in order; the dropped byte is absent.
- Drain and byte on the same edge: collector full, aes_ready and rx_valid(0xAA) on the same edge -> no overflow; the next block starts with 0xAA at [127:120].
- Mid-block reset: send 7 bytes, pulse reset, then send 16 bytes 0x00..0x0F -> output equals exactly 000102...0F.
